// File: rtl/lcd_480_272_timing_gen.sv
// Pixel timing generator for the 480x272 RGB LCD: divides the system clock to the
// pixel rate, scans the raster, publishes x/y and registers the colour to the panel pins.
module lcd_480_272_timing_gen #(
    parameter int unsigned CLK_DIV  = 3,
    parameter int unsigned H_ACTIVE = 480,
    parameter int unsigned H_FP     = 2,
    parameter int unsigned H_SYNC   = 41,
    parameter int unsigned H_BP     = 2,
    parameter int unsigned V_ACTIVE = 272,
    parameter int unsigned V_FP     = 2,
    parameter int unsigned V_SYNC   = 10,
    parameter int unsigned V_BP     = 2
) (
    input  logic       clock,
    input  logic       reset,
    output logic [8:0] x,
    output logic [8:0] y,
    input  logic [4:0] red,
    input  logic [5:0] green,
    input  logic [4:0] blue,
    output logic       pixel_strobe,
    output logic       frame_start,
    output logic       lcd_clk,
    output logic       lcd_de,
    output logic       lcd_hsync,
    output logic       lcd_vsync,
    output logic [4:0] lcd_red,
    output logic [5:0] lcd_green,
    output logic [4:0] lcd_blue
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HW = $clog2(H_TOTAL);
    localparam int unsigned VW = $clog2(V_TOTAL);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_PRE  = DW'(CLK_DIV - 2);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div_cnt, div_next;
    logic [HW-1:0] h_cnt, h_next;
    logic [VW-1:0] v_cnt, v_next;
    logic          strobe;
    logic          active, active_next;
    logic          hsync_on, vsync_on;
    logic          last_pixel;

    always_comb begin
        strobe     = (div_cnt == DIV_LAST);
        div_next   = strobe ? '0 : div_cnt + DW'(1);
        h_next     = h_cnt;
        v_next     = v_cnt;
        last_pixel = (h_cnt == H_LAST) && (v_cnt == V_LAST);
        if (strobe) begin
            if (h_cnt == H_LAST) begin
                h_next = '0;
                v_next = (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
            end else begin
                h_next = h_cnt + HW'(1);
            end
        end
        active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        active_next = (h_next < H_ACT) && (v_next < V_ACT);
        hsync_on    = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vsync_on    = (v_cnt >= VS_START) && (v_cnt < VS_END);
    end

    // pixel_strobe/frame_start are registered one clock early so they line up
    // exactly with div_cnt == CLK_DIV-1, the cycle whose closing edge advances the counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_cnt      <= '0;
            h_cnt        <= '0;
            v_cnt        <= '0;
            x            <= '0;
            y            <= '0;
            lcd_clk      <= 1'b0;
            pixel_strobe <= 1'b0;
            frame_start  <= 1'b0;
            lcd_de       <= 1'b0;
            lcd_hsync    <= 1'b1;
            lcd_vsync    <= 1'b1;
            lcd_red      <= '0;
            lcd_green    <= '0;
            lcd_blue     <= '0;
        end else begin
            div_cnt      <= div_next;
            lcd_clk      <= (div_next >= DIV_HALF);
            pixel_strobe <= (div_cnt == DIV_PRE);
            frame_start  <= (div_cnt == DIV_PRE) && last_pixel;
            h_cnt        <= h_next;
            v_cnt        <= v_next;
            x            <= active_next ? 9'(h_next) : '0;
            y            <= active_next ? 9'(v_next) : '0;
            if (strobe) begin
                lcd_de    <= active;
                lcd_hsync <= !hsync_on;
                lcd_vsync <= !vsync_on;
                lcd_red   <= active ? red   : '0;
                lcd_green <= active ? green : '0;
                lcd_blue  <= active ? blue  : '0;
            end
        end
    end

endmodule

// File: tb/tb_lcd_480_272_timing_gen.sv
// Directed bench for lcd_480_272_timing_gen with a shortened vertical frame so a
// whole frame plus a mid-frame reset fit in a short run.
module tb_lcd_480_272_timing_gen;

    localparam int unsigned H_TOT = 525;
    localparam int unsigned V_TOT = 27;   // 20 active + 2 fp + 3 sync + 2 bp

    logic       clock, reset;
    logic [8:0] x, y;
    logic [4:0] red, blue;
    logic [5:0] green;
    logic       pixel_strobe, frame_start, lcd_clk, lcd_de, lcd_hsync, lcd_vsync;
    logic [4:0] lcd_red, lcd_blue;
    logic [5:0] lcd_green;

    lcd_480_272_timing_gen #(
        .CLK_DIV (3),
        .H_ACTIVE(480),
        .H_FP    (2),
        .H_SYNC  (41),
        .H_BP    (2),
        .V_ACTIVE(20),
        .V_FP    (2),
        .V_SYNC  (3),
        .V_BP    (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .x           (x),
        .y           (y),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .pixel_strobe(pixel_strobe),
        .frame_start (frame_start),
        .lcd_clk     (lcd_clk),
        .lcd_de      (lcd_de),
        .lcd_hsync   (lcd_hsync),
        .lcd_vsync   (lcd_vsync),
        .lcd_red     (lcd_red),
        .lcd_green   (lcd_green),
        .lcd_blue    (lcd_blue)
    );

    // Pixel logic: colour is a pure function of the published coordinate.
    assign red   = x[4:0];
    assign green = y[5:0];
    assign blue  = 5'd31;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int nchecks = 0;
    int nerr    = 0;
    int cyc     = 0;   // rising edges since reset release

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clock) begin
        if (reset) cyc = cyc + 1;
        else       cyc = 0;
    end

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    function automatic int unsigned pix(input int unsigned h, input int unsigned v, input int unsigned f);
        return f * H_TOT * V_TOT + v * H_TOT + h;
    endfunction

    // Event monitor, sampled on the falling clock edge.
    int  de_rise[2] = '{-1, -1};
    int  n_de_rise = 0;
    int  de_fall = -1, hs_fall = -1, hs_rise = -1, vs_fall = -1, vs_rise = -1;
    int  fs_cyc = -1, fs_count = 0, de_clocks = 0, blank_bad = 0, de_blue_bad = 0;
    logic p_de = 1'b0, p_hs = 1'b1, p_vs = 1'b1;

    always @(negedge clock) begin
        if (reset && cyc > 0) begin
            if (lcd_de && !p_de && n_de_rise < 2) begin
                de_rise[n_de_rise] = cyc;
                n_de_rise++;
            end
            if (!lcd_de && p_de && de_fall < 0) de_fall = cyc;
            if (!lcd_hsync && p_hs && hs_fall < 0) hs_fall = cyc;
            if (lcd_hsync && !p_hs && hs_rise < 0) hs_rise = cyc;
            if (!lcd_vsync && p_vs && vs_fall < 0) vs_fall = cyc;
            if (lcd_vsync && !p_vs && vs_rise < 0) vs_rise = cyc;
            if (frame_start) begin
                fs_count++;
                if (fs_cyc < 0) fs_cyc = cyc;
            end
            if (lcd_de && cyc <= 42525) de_clocks++;
            if (!lcd_de && {lcd_red, lcd_green, lcd_blue} != 16'd0) blank_bad++;
            if (lcd_de && lcd_blue != 5'd31) de_blue_bad++;
        end
        p_de = lcd_de;
        p_hs = lcd_hsync;
        p_vs = lcd_vsync;
    end

    typedef struct {
        int unsigned k;
        logic de, hs, vs;
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        logic [8:0] ex, ey;
    } vec_t;

    vec_t vecs[18];

    initial begin
        #(70000 * 10);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Pins for pixel k are checked after edge 3*(k+1); x/y then show pixel k+1.
        vecs[0]  = '{pix(0,0,0),    1, 1, 1, 5'd0,  6'd0,  5'd31, 9'd1,   9'd0};
        vecs[1]  = '{pix(5,0,0),    1, 1, 1, 5'd5,  6'd0,  5'd31, 9'd6,   9'd0};
        vecs[2]  = '{pix(479,0,0),  1, 1, 1, 5'd31, 6'd0,  5'd31, 9'd0,   9'd0};
        vecs[3]  = '{pix(480,0,0),  0, 1, 1, 5'd0,  6'd0,  5'd0,  9'd0,   9'd0};
        vecs[4]  = '{pix(481,0,0),  0, 1, 1, 5'd0,  6'd0,  5'd0,  9'd0,   9'd0};
        vecs[5]  = '{pix(482,0,0),  0, 0, 1, 5'd0,  6'd0,  5'd0,  9'd0,   9'd0};
        vecs[6]  = '{pix(522,0,0),  0, 0, 1, 5'd0,  6'd0,  5'd0,  9'd0,   9'd0};
        vecs[7]  = '{pix(523,0,0),  0, 1, 1, 5'd0,  6'd0,  5'd0,  9'd0,   9'd0};
        vecs[8]  = '{pix(524,0,0),  0, 1, 1, 5'd0,  6'd0,  5'd0,  9'd0,   9'd1};
        vecs[9]  = '{pix(0,1,0),    1, 1, 1, 5'd0,  6'd1,  5'd31, 9'd1,   9'd1};
        vecs[10] = '{pix(37,7,0),   1, 1, 1, 5'd5,  6'd7,  5'd31, 9'd38,  9'd7};
        vecs[11] = '{pix(100,19,0), 1, 1, 1, 5'd4,  6'd19, 5'd31, 9'd101, 9'd19};
        vecs[12] = '{pix(0,20,0),   0, 1, 1, 5'd0,  6'd0,  5'd0,  9'd0,   9'd0};
        vecs[13] = '{pix(10,22,0),  0, 1, 0, 5'd0,  6'd0,  5'd0,  9'd0,   9'd0};
        vecs[14] = '{pix(482,24,0), 0, 0, 0, 5'd0,  6'd0,  5'd0,  9'd0,   9'd0};
        vecs[15] = '{pix(0,25,0),   0, 1, 1, 5'd0,  6'd0,  5'd0,  9'd0,   9'd0};
        vecs[16] = '{pix(524,26,0), 0, 1, 1, 5'd0,  6'd0,  5'd0,  9'd0,   9'd0};
        vecs[17] = '{pix(0,0,1),    1, 1, 1, 5'd0,  6'd0,  5'd31, 9'd1,   9'd0};

        reset = 1'b1;
        #3 reset = 1'b0;
        repeat (4) @(negedge clock);
        chk("rst x", x, 0);
        chk("rst y", y, 0);
        chk("rst de", lcd_de, 0);
        chk("rst hsync", lcd_hsync, 1);
        chk("rst vsync", lcd_vsync, 1);
        chk("rst lcd_clk", lcd_clk, 0);
        chk("rst strobe", pixel_strobe, 0);
        chk("rst frame_start", frame_start, 0);
        chk("rst rgb", {lcd_red, lcd_green, lcd_blue}, 0);
        reset = 1'b1;

        wait_cyc(1);
        chk("c1 strobe", pixel_strobe, 0);
        chk("c1 lcd_clk", lcd_clk, 1);
        wait_cyc(2);
        chk("c2 strobe", pixel_strobe, 1);
        chk("c2 de", lcd_de, 0);
        wait_cyc(3);
        chk("c3 strobe", pixel_strobe, 0);
        chk("c3 lcd_clk", lcd_clk, 0);

        for (int i = 0; i < 18; i++) begin
            wait_cyc(3 * (vecs[i].k + 1));
            chk($sformatf("vec%0d de", i), lcd_de, vecs[i].de);
            chk($sformatf("vec%0d hsync", i), lcd_hsync, vecs[i].hs);
            chk($sformatf("vec%0d vsync", i), lcd_vsync, vecs[i].vs);
            chk($sformatf("vec%0d red", i), lcd_red, vecs[i].r);
            chk($sformatf("vec%0d green", i), lcd_green, vecs[i].g);
            chk($sformatf("vec%0d blue", i), lcd_blue, vecs[i].b);
            chk($sformatf("vec%0d x", i), x, vecs[i].ex);
            chk($sformatf("vec%0d y", i), y, vecs[i].ey);
        end

        chk("de first rise", de_rise[0], 3);
        chk("line period", de_rise[1] - de_rise[0], 1575);
        chk("de width", de_fall - de_rise[0], 1440);
        chk("hsync offset", hs_fall - de_rise[0], 1446);
        chk("hsync width", hs_rise - hs_fall, 123);
        chk("vsync start", vs_fall, 34653);
        chk("vsync width", vs_rise - vs_fall, 4725);
        chk("frame_start cycle", fs_cyc, 42524);
        chk("frame_start count", fs_count, 1);
        chk("de clocks per frame", de_clocks, 28800);

        // Mid-frame reset at pixel (200,5) of the second frame.
        wait_cyc(3 * (pix(200, 5, 1) + 1));
        chk("pre-rst de", lcd_de, 1);
        chk("pre-rst x", x, 201);
        chk("pre-rst y", y, 5);
        chk("pre-rst red", lcd_red, 8);
        reset = 1'b0;
        #1;
        chk("mid-rst de", lcd_de, 0);
        chk("mid-rst hsync", lcd_hsync, 1);
        chk("mid-rst vsync", lcd_vsync, 1);
        chk("mid-rst x", x, 0);
        chk("mid-rst y", y, 0);
        chk("mid-rst rgb", {lcd_red, lcd_green, lcd_blue}, 0);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        wait_cyc(2);
        chk("rel c2 strobe", pixel_strobe, 1);
        chk("rel c2 de", lcd_de, 0);
        wait_cyc(3);
        chk("rel c3 de", lcd_de, 1);
        chk("rel c3 x", x, 1);
        chk("rel c3 y", y, 0);
        chk("rel c3 rgb", {lcd_red, lcd_green, lcd_blue}, {5'd0, 6'd0, 5'd31});

        chk("blank not black", blank_bad, 0);
        chk("de blue wrong", de_blue_bad, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
